// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receiver.
`timescale 1ns/1ps

package uart_pkg;

  // Receiver frame-level states; PARITY is unused in 8N1 builds.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int NDATA = 8;

  // Even-parity check over {parity, data}: 1 when the count of ones is odd.
  function automatic logic parity_odd(input logic [8:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: 16-bit bit-period counter for the UART receiver.
// Counts up from 0, wraps at DIV-1, and is forced to 0 while clear is high.
// mid_start marks the middle of the start bit, bit_tick the middle of each
// following bit (counter restarts at mid-start, so DIV-1 lands at mid-bit).
`timescale 1ns/1ps

module uart_baud_counter #(
  parameter int unsigned DIV  = 5208,
  parameter int unsigned HALF = 2604
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        clear,
  output logic [15:0] count,
  output logic        mid_start,
  output logic        bit_tick
);

  assign mid_start = (count == 16'(HALF - 1));
  assign bit_tick  = (count == 16'(DIV - 1));

  // Free-running bit-period counter with synchronous clear and wrap.
  always_ff @(posedge clk or posedge nRst) begin
    if (nRst) begin
      count <= '0;
    end else if (clear || bit_tick) begin
      count <= '0;
    end else begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: UART deserialiser, start + 8 data bits LSB-first
// (+ even parity when UART_RX_PARITY_EN is defined) + stop.
// Macro: UART_RX_PARITY_EN -- defined: 8E1 framing; undefined: 8N1 framing,
// parity_error held at 0 and working_data[8] held at 0.
// Reset nRst is asynchronous and active-high despite its name.
`timescale 1ns/1ps

module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned CLOCK_FREQ = 50000000
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        enable,
  input  logic        Rx,
  output logic [7:0]  data_out,
  output logic        data_ready,
  output logic [8:0]  working_data,
  output logic [3:0]  bits_received,
  output logic        receiving,
  output logic [15:0] BAUD_counter,
  output logic        parity_error
);

  localparam int unsigned DIV  = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned HALF = DIV / 2;

  rx_state_t state;
  logic      mid_start;
  logic      bit_tick;
  logic      baud_clear;
  logic      frame_good;  // stop bit seen high; publish on the next edge
  logic      rearm_wait;  // after a framing error, wait for Rx high

  // Counter idles at 0 and restarts at mid-start so later ticks hit mid-bit.
  assign baud_clear = !enable || (state == IDLE) || ((state == START) && mid_start);

  uart_baud_counter #(
    .DIV  (DIV),
    .HALF (HALF)
  ) u_baud (
    .clk       (clk),
    .nRst      (nRst),
    .clear     (baud_clear),
    .count     (BAUD_counter),
    .mid_start (mid_start),
    .bit_tick  (bit_tick)
  );

  // Frame FSM, shift register and registered outputs.
  always_ff @(posedge clk or posedge nRst) begin
    if (nRst) begin
      state         <= IDLE;
      data_out      <= '0;
      data_ready    <= 1'b0;
      working_data  <= '0;
      bits_received <= '0;
      receiving     <= 1'b0;
      parity_error  <= 1'b0;
      frame_good    <= 1'b0;
      rearm_wait    <= 1'b0;
    end else begin
      // NOTE: later non-blocking writes in this block override these
      // defaults, so pulses need no explicit clear branch.
      data_ready <= 1'b0;
      frame_good <= 1'b0;

      if (frame_good) begin
        data_out   <= working_data[7:0];
        data_ready <= 1'b1;
`ifdef UART_RX_PARITY_EN
        parity_error <= parity_odd(working_data);
`else
        parity_error <= 1'b0;
`endif
      end

      if (!enable) begin
        state     <= IDLE;
        receiving <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (Rx) begin
              rearm_wait <= 1'b0;
            end else if (!rearm_wait) begin
              state         <= START;
              receiving     <= 1'b1;
              working_data  <= '0;
              bits_received <= '0;
            end
          end

          START: begin
            if (mid_start) begin
              if (Rx) begin
                state     <= IDLE;
                receiving <= 1'b0;
              end else begin
                state <= DATA;
              end
            end
          end

          DATA: begin
            if (bit_tick) begin
`ifdef UART_RX_PARITY_EN
              working_data <= {Rx, working_data[8:1]};
`else
              working_data <= {1'b0, Rx, working_data[7:1]};
`endif
              bits_received <= bits_received + 4'd1;
              if (bits_received == 4'(NDATA - 1)) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end
          end

`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (bit_tick) begin
              working_data  <= {Rx, working_data[8:1]};
              bits_received <= bits_received + 4'd1;
              state         <= STOP;
            end
          end
`endif

          STOP: begin
            if (bit_tick) begin
              state     <= IDLE;
              receiving <= 1'b0;
              if (Rx) begin
                frame_good <= 1'b1;
              end else begin
                rearm_wait <= 1'b1;
              end
            end
          end

          default: begin
            state     <= IDLE;
            receiving <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed self-checking bench for uart_receiver.
// Runs with a short bit period (DIV=20) so every scenario fits a small budget.
// Follows UART_RX_PARITY_EN the same way the design does.
`timescale 1ns/1ps

module tb_uart_receiver;

  localparam int unsigned BAUD = 9600;
  localparam int unsigned CLKF = 9600 * 20;
  localparam int DIV  = 20;
  localparam int HALF = 10;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic        tb_clk = 1'b0;
  logic        nRst;
  logic        enable;
  logic        rx;
  logic [7:0]  data_out;
  logic        data_ready;
  logic [8:0]  working_data;
  logic [3:0]  bits_received;
  logic        receiving;
  logic [15:0] baud_counter;
  logic        parity_error;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ready_cnt = 0;
  int ready_cyc = -1;
  logic ready_recv = 1'b1;

  uart_receiver #(
    .BAUD_RATE  (BAUD),
    .CLOCK_FREQ (CLKF)
  ) dut (
    .clk           (tb_clk),
    .nRst          (nRst),
    .enable        (enable),
    .Rx            (rx),
    .data_out      (data_out),
    .data_ready    (data_ready),
    .working_data  (working_data),
    .bits_received (bits_received),
    .receiving     (receiving),
    .BAUD_counter  (baud_counter),
    .parity_error  (parity_error)
  );

  always #5 tb_clk = ~tb_clk;

  always @(posedge tb_clk) cyc <= cyc + 1;

  // Strobe monitor, sampled away from the active edge.
  always @(negedge tb_clk) begin
    if (data_ready) begin
      ready_cnt  = ready_cnt + 1;
      ready_cyc  = cyc;
      ready_recv = receiving;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (DIV) @(posedge tb_clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data_out"}, 32'(data_out), 32'h0);
    check({tag, "_data_ready"}, 32'(data_ready), 32'h0);
    check({tag, "_working"}, 32'(working_data), 32'h0);
    check({tag, "_bits"}, 32'(bits_received), 32'h0);
    check({tag, "_receiving"}, 32'(receiving), 32'h0);
    check({tag, "_counter"}, 32'(baud_counter), 32'h0);
    check({tag, "_perr"}, 32'(parity_error), 32'h0);
  endtask

  // Drives one full frame; returns the edge index of start detection.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop_bit,
                            output int t0);
    @(posedge tb_clk);
    #1;
    rx = 1'b0;
    t0 = cyc + 1;
    @(posedge tb_clk);
    #1;
    check("start_receiving", 32'(receiving), 32'h1);
    check("start_counter", 32'(baud_counter), 32'h0);
    repeat (DIV - 1) @(posedge tb_clk);
    #1;
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR == 1) drive_bit(p);
    drive_bit(stop_bit);
    rx = 1'b1;
  endtask

  task automatic rx_good(input string tag, input logic [7:0] d, input logic p,
                         input logic exp_perr);
    int t0;
    int cnt0;
    cnt0 = ready_cnt;
    send_frame(d, p, 1'b1, t0);
    repeat (5) @(posedge tb_clk);
    #1;
    check({tag, "_strobes"}, 32'(ready_cnt - cnt0), 32'd1);
    check({tag, "_strobe_cyc"}, 32'(ready_cyc), 32'(t0 + HALF + (9 + PAR) * DIV + 1));
    check({tag, "_recv_at_strobe"}, 32'(ready_recv), 32'h0);
    check({tag, "_data_out"}, 32'(data_out), 32'(d));
    check({tag, "_perr"}, 32'(parity_error), (PAR == 1) ? 32'(exp_perr) : 32'h0);
    check({tag, "_working"}, 32'(working_data), (PAR == 1) ? 32'({p, d}) : 32'({1'b0, d}));
    check({tag, "_bits"}, 32'(bits_received), 32'(8 + PAR));
    check({tag, "_receiving"}, 32'(receiving), 32'h0);
    check({tag, "_counter"}, 32'(baud_counter), 32'h0);
  endtask

  initial begin
    int t0;
    int cnt0;

    nRst   = 1'b1;
    enable = 1'b1;
    rx     = 1'b1;
    repeat (3) @(posedge tb_clk);
    #1;
    check_all_zero("in_reset");
    nRst = 1'b0;

    // Idle line after reset.
    repeat (200) @(posedge tb_clk);
    #1;
    check_all_zero("idle");

    // Good frames.
    rx_good("f0f", 8'h0F, 1'b0, 1'b0);
    rx_good("f01", 8'h01, 1'b0, 1'b1);

    // False start: low for less than half a bit.
    cnt0 = ready_cnt;
    @(posedge tb_clk);
    #1;
    rx = 1'b0;
    repeat (4) @(posedge tb_clk);
    #1;
    check("fs_receiving_hi", 32'(receiving), 32'h1);
    rx = 1'b1;
    repeat (3 * DIV) @(posedge tb_clk);
    #1;
    check("fs_receiving", 32'(receiving), 32'h0);
    check("fs_strobes", 32'(ready_cnt - cnt0), 32'd0);
    check("fs_counter", 32'(baud_counter), 32'h0);
    check("fs_data_out", 32'(data_out), 32'h01);

    // Framing error: stop bit low.
    cnt0 = ready_cnt;
    send_frame(8'hA5, 1'b0, 1'b0, t0);
    repeat (2 * DIV) @(posedge tb_clk);
    #1;
    check("fe_strobes", 32'(ready_cnt - cnt0), 32'd0);
    check("fe_data_out", 32'(data_out), 32'h01);
    check("fe_perr", 32'(parity_error), (PAR == 1) ? 32'h1 : 32'h0);
    check("fe_working", 32'(working_data), 32'h0A5);
    check("fe_receiving", 32'(receiving), 32'h0);

    // enable dropped mid-frame.
    cnt0 = ready_cnt;
    @(posedge tb_clk);
    #1;
    rx = 1'b0;
    repeat (HALF + DIV + 3) @(posedge tb_clk);
    #1;
    check("en_bits_mid", 32'(bits_received), 32'h1);
    enable = 1'b0;
    rx     = 1'b1;
    @(posedge tb_clk);
    #1;
    check("en_receiving", 32'(receiving), 32'h0);
    check("en_counter", 32'(baud_counter), 32'h0);
    enable = 1'b1;
    repeat (2 * DIV) @(posedge tb_clk);
    #1;
    check("en_strobes", 32'(ready_cnt - cnt0), 32'd0);
    check("en_data_out", 32'(data_out), 32'h01);

    // Reset mid-frame after bit 3 of 0x3C.
    @(posedge tb_clk);
    #1;
    rx = 1'b0;
    repeat (DIV) @(posedge tb_clk);
    #1;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("mid_bits", 32'(bits_received), 32'h4);
    check("mid_working", 32'(working_data), (PAR == 1) ? 32'h180 : 32'h0C0);
    nRst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    rx = 1'b1;
    repeat (3) @(posedge tb_clk);
    #1;
    nRst = 1'b0;
    repeat (2 * DIV) @(posedge tb_clk);
    #1;
    rx_good("f3c", 8'h3C, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
